// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared types and default sizing for the receive FIFO read sequencer.
package rx_fifo_ctrl_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int LEN_W_DEF   = 8;
   localparam int TO_W_DEF    = 8;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [2:0] {
      IDLE,
      XFER,
      DRAIN,
      DONE,
      ABORT
   } state_t;

endpackage

// File: rtl/rx_fifo_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the sequencer.
interface rx_fifo_ctrl_if
   import rx_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic              fifo_r_enable;
   logic [DATA_W-1:0] fifo_r_data;
   logic              fifo_empty;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   // Sequencer side: pops the FIFO and sources the stream.
   modport master (
      output fifo_r_enable, m_data, m_valid,
      input  fifo_r_data, fifo_empty, m_ready
   );

   // FIFO and consumer side.
   modport slave (
      input  fifo_r_enable, m_data, m_valid,
      output fifo_r_data, fifo_empty, m_ready
   );
endinterface

// File: rtl/rx_timeout_counter.sv
// Stall counter with clear and enable. at_limit is a registered look-ahead
// flag: it is high when the next enabled step would reach the rollover value,
// so the owner can act on the same edge the limit is reached. On that step the
// count wraps back to zero.
module rx_timeout_counter #(
   parameter int TO_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            count_enable,
   input  logic [TO_W-1:0] rollover,
   output logic            at_limit
);
   logic [TO_W-1:0] value;
   logic [TO_W-1:0] value_next;
   logic [TO_W-1:0] value_inc;

   assign value_inc = value + TO_W'(1);

   // Next count: clear wins, otherwise step and wrap on reaching rollover.
   always_comb begin
      // NOTE: default first so every path assigns value_next and no latch is inferred.
      value_next = value;
      if (clear) begin
         value_next = '0;
      end else if (count_enable) begin
         value_next = (value_inc == rollover) ? '0 : value_inc;
      end
   end

   // Count register and look-ahead limit flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value    <= '0;
         at_limit <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         value    <= value_next;
         at_limit <= (value_next == rollover - TO_W'(1));
      end
   end
endmodule

// File: rtl/rx_fifo_ctrl.sv
// Read-side sequencer: pops len bytes from the RX FIFO into a registered
// valid/ready stream at one byte per cycle, counts accepted bytes and aborts
// if the FIFO stays empty for TIMEOUT consecutive non-backpressured cycles.
module rx_fifo_ctrl
   import rx_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TO_W    = TO_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic [LEN_W-1:0] count,
   rx_fifo_ctrl_if.master   bus
);
   state_t            state;
   logic [LEN_W-1:0]  remaining;
   logic [DATA_W-1:0] head;
   logic              pop;
   logic              handshake;
   logic              accept;
   logic              to_clear;
   logic              to_enable;
   logic              to_at_limit;
   logic              to_expire;

   assign head      = bus.fifo_r_data;
   assign handshake = bus.m_valid & bus.m_ready;
   assign accept    = (state == IDLE) & start;

   // Pop only when the output register is free or being emptied this cycle.
   assign pop = (state == XFER) & ~bus.fifo_empty & (remaining != '0)
              & (~bus.m_valid | bus.m_ready);
   assign bus.fifo_r_enable = pop;

   // Empty-FIFO stall cycles count; downstream backpressure freezes the count.
   assign to_clear  = (state != XFER) | pop;
   assign to_enable = (state == XFER) & bus.fifo_empty & (remaining != '0)
                    & ~(bus.m_valid & ~bus.m_ready);
   assign to_expire = to_enable & to_at_limit;

   rx_timeout_counter #(
      .TO_W (TO_W)
   ) u_timeout (
      .clk          (clk),
      .rst          (rst),
      .clear        (to_clear),
      .count_enable (to_enable),
      .rollover     (TO_W'(TIMEOUT)),
      .at_limit     (to_at_limit)
   );

   // Output register, bytes left to pop and bytes accepted downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.m_data  <= '0;
         bus.m_valid <= 1'b0;
         remaining   <= '0;
         count       <= '0;
      end else begin
         if (pop) begin
            bus.m_data  <= head;
            bus.m_valid <= 1'b1;
         end else if (handshake) begin
            bus.m_valid <= 1'b0;
         end

         if (accept) begin
            remaining <= len;
         end else if (pop) begin
            remaining <= remaining - LEN_W'(1);
         end

         if (accept) begin
            count <= '0;
         end else if (handshake) begin
            count <= count + LEN_W'(1);
         end
      end
   end

   // Burst sequencing with registered busy/done/err_timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         done        <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= XFER;
                  end
               end
            end
            XFER: begin
               if (pop && (remaining == LEN_W'(1))) begin
                  state <= DRAIN;
               end else if (to_expire) begin
                  state <= ABORT;
               end
            end
            DRAIN: begin
               if (~bus.m_valid | bus.m_ready) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            ABORT: begin
               if (~bus.m_valid | bus.m_ready) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  err_timeout <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
